// File: rtl/mem_host_dma_pkg.sv
// Shared types and default widths for the host-side line DMA that sits below mem_system.
package mem_host_pkg;

    localparam int LINE_W_DEF = 512;
    localparam int BEAT_W_DEF = 64;
    localparam int ADDR_W_DEF = 32;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_RSVD = 2'b11
    } host_op_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_CMD,
        RD_DATA,
        WR_CMD,
        WR_DATA,
        DONE
    } dma_state_t;

endpackage

// File: rtl/mem_host_dma_if.sv
// Narrow host memory bus: one command channel, a write-beat channel and a read-beat channel.
interface mem_host_dma_if
    import mem_host_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int BEAT_W = BEAT_W_DEF
);

    logic              host_cmd_valid;
    logic              host_cmd_ready;
    logic              host_cmd_we;
    logic [ADDR_W-1:0] host_cmd_addr;
    logic [BEAT_W-1:0] host_wdata;
    logic              host_wdata_valid;
    logic              host_wdata_ready;
    logic [BEAT_W-1:0] host_rdata;
    logic              host_rdata_valid;

    modport master (
        output host_cmd_valid, host_cmd_we, host_cmd_addr,
        output host_wdata, host_wdata_valid,
        input  host_cmd_ready, host_wdata_ready,
        input  host_rdata, host_rdata_valid
    );

    modport slave (
        input  host_cmd_valid, host_cmd_we, host_cmd_addr,
        input  host_wdata, host_wdata_valid,
        output host_cmd_ready, host_wdata_ready,
        output host_rdata, host_rdata_valid
    );

endinterface

// File: rtl/mem_host_dma_line_serdes.sv
// Line buffer with beat counter: scatters read beats into the line and selects write beats out of it.
module line_serdes
    import mem_host_pkg::*;
#(
    parameter int LINE_W = LINE_W_DEF,
    parameter int BEAT_W = BEAT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_line,
    input  logic [LINE_W-1:0] line_in,
    input  logic              clr_cnt,
    input  logic              rd_beat_en,
    input  logic              wr_beat_en,
    input  logic [BEAT_W-1:0] beat_in,
    output logic [BEAT_W-1:0] beat_out,
    output logic [LINE_W-1:0] line_out,
    output logic              last_beat
);

    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [LINE_W-1:0] line_q;
    logic [CNT_W-1:0]  cnt_q;

    // Beat 0 lands in the least-significant slice of the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q <= '0;
        end else if (load_line) begin
            line_q <= line_in;
        end else if (rd_beat_en) begin
            line_q[cnt_q*BEAT_W +: BEAT_W] <= beat_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_cnt) begin
            cnt_q <= '0;
        end else if (rd_beat_en || wr_beat_en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign beat_out  = line_q[cnt_q*BEAT_W +: BEAT_W];
    assign line_out  = line_q;
    assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

endmodule

// File: rtl/mem_host_dma.sv
// Host-side DMA for the cache: turns line fills/writebacks into a command plus a beat burst.
module mem_host_dma
    import mem_host_pkg::*;
#(
    parameter int LINE_W = LINE_W_DEF,
    parameter int BEAT_W = BEAT_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          op_host,
    input  logic [ADDR_W-1:0]   AddrOut_host,
    input  logic [LINE_W-1:0]   DataOut_host,
    output logic [LINE_W-1:0]   DataIn_host,
    output logic                tx_done_host,
    output logic                rd_valid_host,
    mem_host_dma_if.master      host,
    output logic                busy,
    output logic                proto_err
);

    localparam int OFS_W = $clog2(LINE_W / 8);

    dma_state_t        state_q, state_d;
    host_op_t          op;
    logic [ADDR_W-1:0] addr_q;
    logic              rd_op_q;
    logic [LINE_W-1:0] data_in_q;
    logic [LINE_W-1:0] line_out;
    logic [BEAT_W-1:0] beat_out;
    logic              last_beat;
    logic              load_line, clr_cnt, rd_beat_en, wr_beat_en;
    logic              start;
    logic              addr_unused;

    assign op          = host_op_t'(op_host);
    assign start       = (state_q == IDLE) && (op == OP_RD || op == OP_WR);
    assign addr_unused = ^AddrOut_host[OFS_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (op == OP_RD)      state_d = RD_CMD;
                else if (op == OP_WR) state_d = WR_CMD;
            end
            RD_CMD:  if (host.host_cmd_ready) state_d = RD_DATA;
            WR_CMD:  if (host.host_cmd_ready) state_d = WR_DATA;
            RD_DATA: if (host.host_rdata_valid && last_beat) state_d = DONE;
            WR_DATA: if (host.host_wdata_ready && last_beat) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs are forced to zero outside the states that own them so idle/reset looks clean.
    always_comb begin
        host.host_cmd_valid   = 1'b0;
        host.host_cmd_we      = 1'b0;
        host.host_cmd_addr    = '0;
        host.host_wdata       = '0;
        host.host_wdata_valid = 1'b0;
        tx_done_host          = 1'b0;
        rd_valid_host         = 1'b0;
        load_line             = 1'b0;
        clr_cnt               = 1'b0;
        rd_beat_en            = 1'b0;
        wr_beat_en            = 1'b0;
        busy                  = (state_q != IDLE);
        case (state_q)
            IDLE: load_line = (op == OP_WR);
            RD_CMD, WR_CMD: begin
                host.host_cmd_valid = 1'b1;
                host.host_cmd_we    = (state_q == WR_CMD);
                host.host_cmd_addr  = addr_q;
                clr_cnt             = host.host_cmd_ready;
            end
            RD_DATA: rd_beat_en = host.host_rdata_valid;
            WR_DATA: begin
                host.host_wdata       = beat_out;
                host.host_wdata_valid = 1'b1;
                wr_beat_en            = host.host_wdata_ready;
            end
            DONE: begin
                tx_done_host  = 1'b1;
                rd_valid_host = rd_op_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            rd_op_q <= 1'b0;
        end else if (start) begin
            addr_q  <= {AddrOut_host[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
            rd_op_q <= (op == OP_RD);
        end
    end

    // The cache sees the live line during DONE and a held copy afterwards; writes never touch it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                data_in_q <= '0;
        else if (rd_valid_host) data_in_q <= line_out;
    end

    assign DataIn_host = rd_valid_host ? line_out : data_in_q;

    // A read beat is only legal while a read burst is collecting data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                               proto_err <= 1'b0;
        else if (host.host_rdata_valid && state_q != RD_DATA) proto_err <= 1'b1;
    end

    line_serdes #(
        .LINE_W (LINE_W),
        .BEAT_W (BEAT_W)
    ) u_serdes (
        .clk        (clk),
        .rst        (rst),
        .load_line  (load_line),
        .line_in    (DataOut_host),
        .clr_cnt    (clr_cnt),
        .rd_beat_en (rd_beat_en),
        .wr_beat_en (wr_beat_en),
        .beat_in    (host.host_rdata),
        .beat_out   (beat_out),
        .line_out   (line_out),
        .last_beat  (last_beat)
    );

endmodule

// File: tb/tb_mem_host_dma.sv
// Scoreboard bench for mem_host_dma: stimulus tasks queue expectations, a negedge monitor checks them.
module tb_mem_host_dma;
    import mem_host_pkg::*;

    localparam int LINE_W = 512;
    localparam int BEAT_W = 64;
    localparam int ADDR_W = 32;
    localparam int BEATS  = 8;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
    } cmd_exp_t;

    typedef struct {
        int                cyc;
        logic              rd;
        logic [LINE_W-1:0] line;
    } done_exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        op_host;
    logic [ADDR_W-1:0] AddrOut_host;
    logic [LINE_W-1:0] DataOut_host;
    logic [LINE_W-1:0] DataIn_host;
    logic              tx_done_host;
    logic              rd_valid_host;
    logic              busy;
    logic              proto_err;

    mem_host_dma_if #(.ADDR_W(ADDR_W), .BEAT_W(BEAT_W)) bus ();

    mem_host_dma #(
        .LINE_W (LINE_W),
        .BEAT_W (BEAT_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .op_host       (op_host),
        .AddrOut_host  (AddrOut_host),
        .DataOut_host  (DataOut_host),
        .DataIn_host   (DataIn_host),
        .tx_done_host  (tx_done_host),
        .rd_valid_host (rd_valid_host),
        .host          (bus.master),
        .busy          (busy),
        .proto_err     (proto_err)
    );

    always #5 clk = ~clk;

    int                compared   = 0;
    int                mismatched = 0;
    int                cyc        = 0;
    cmd_exp_t          cmd_q[$];
    logic [BEAT_W-1:0] wq[$];
    done_exp_t         done_q[$];
    logic [LINE_W-1:0] last_line = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [LINE_W-1:0] act,
                                input logic [LINE_W-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag_unexpected(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: got event expected none at cycle %0d", name, cyc);
    endtask

    // Monitor: every handshake or completion pops and compares the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.host_cmd_valid && bus.host_cmd_ready) begin
                if (cmd_q.size() == 0) flag_unexpected("cmd_unexpected");
                else begin
                    cmd_exp_t c;
                    c = cmd_q.pop_front();
                    check_output("cmd_we", LINE_W'(bus.host_cmd_we), LINE_W'(c.we));
                    check_output("cmd_addr", LINE_W'(bus.host_cmd_addr), LINE_W'(c.addr));
                end
            end
            if (bus.host_wdata_valid && bus.host_wdata_ready) begin
                if (wq.size() == 0) flag_unexpected("wbeat_unexpected");
                else check_output("wbeat", LINE_W'(bus.host_wdata), LINE_W'(wq.pop_front()));
            end
            if (tx_done_host) begin
                if (done_q.size() == 0) flag_unexpected("done_unexpected");
                else begin
                    done_exp_t d;
                    d = done_q.pop_front();
                    check_output("done_cycle", LINE_W'(cyc), LINE_W'(d.cyc));
                    check_output("done_rd_valid", LINE_W'(rd_valid_host), LINE_W'(d.rd));
                    check_output("done_data_in", DataIn_host, d.line);
                end
            end
        end
    end

    task automatic check_all_zero(input string name);
        check_output({name, "_data_in"}, DataIn_host, '0);
        check_output({name, "_ctrl"},
                     LINE_W'({tx_done_host, rd_valid_host, bus.host_cmd_valid, bus.host_cmd_we,
                              bus.host_wdata_valid, busy, proto_err}), '0);
        check_output({name, "_addr_wdata"}, LINE_W'({bus.host_cmd_addr, bus.host_wdata}), '0);
    endtask

    task automatic apply_read(input logic [ADDR_W-1:0] addr, input logic [ADDR_W-1:0] exp_addr,
                              input logic [BEAT_W-1:0] base, input int stall, input int rst_beat);
        logic [LINE_W-1:0] line;
        int                c0;
        bit                aborted;
        aborted = 1'b0;
        for (int i = 0; i < BEATS; i++) line[i*BEAT_W +: BEAT_W] = base + BEAT_W'(i);
        @(posedge clk); #1;
        op_host      = 2'b01;
        AddrOut_host = addr;
        c0           = cyc;
        cmd_q.push_back('{we: 1'b0, addr: exp_addr});
        if (rst_beat < 0) begin
            done_q.push_back('{cyc: c0 + 10 + stall, rd: 1'b1, line: line});
            last_line = line;
        end
        @(posedge clk); #1;
        op_host      = 2'b00;
        AddrOut_host = '1;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check_output("stall_cmd_valid", LINE_W'(bus.host_cmd_valid), LINE_W'(1'b1));
            check_output("stall_cmd_we", LINE_W'(bus.host_cmd_we), '0);
            check_output("stall_cmd_addr", LINE_W'(bus.host_cmd_addr), LINE_W'(exp_addr));
            check_output("stall_busy", LINE_W'(busy), LINE_W'(1'b1));
            @(posedge clk); #1;
        end
        bus.host_cmd_ready = 1'b1;
        @(posedge clk); #1;
        bus.host_cmd_ready = 1'b0;
        for (int i = 0; i < BEATS && !aborted; i++) begin
            bus.host_rdata       = base + BEAT_W'(i);
            bus.host_rdata_valid = 1'b1;
            if (i == rst_beat) begin
                #1 rst = 1'b1;
                #1 check_all_zero("midburst_reset");
                bus.host_rdata_valid = 1'b0;
                #1 rst = 1'b0;
                last_line = '0;
                aborted   = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        bus.host_rdata_valid = 1'b0;
        if (aborted) begin
            @(negedge clk);
            check_output("reset_busy", LINE_W'(busy), '0);
        end
    endtask

    task automatic apply_write(input logic [ADDR_W-1:0] addr, input logic [ADDR_W-1:0] exp_addr,
                               input logic [BEAT_W-1:0] base, input bit toggle);
        logic [LINE_W-1:0] line;
        int                c0;
        int                accepted;
        int                j;
        for (int k = 0; k < BEATS; k++) line[k*BEAT_W +: BEAT_W] = base + BEAT_W'(k);
        @(posedge clk); #1;
        op_host      = 2'b10;
        AddrOut_host = addr;
        DataOut_host = line;
        c0           = cyc;
        cmd_q.push_back('{we: 1'b1, addr: exp_addr});
        for (int k = 0; k < BEATS; k++) wq.push_back(base + BEAT_W'(k));
        done_q.push_back('{cyc: c0 + (toggle ? 17 : 10), rd: 1'b0, line: last_line});
        @(posedge clk); #1;
        op_host      = 2'b00;
        AddrOut_host = '0;
        DataOut_host = '1;
        bus.host_cmd_ready = 1'b1;
        @(posedge clk); #1;
        bus.host_cmd_ready = 1'b0;
        accepted = 0;
        j        = 0;
        while (accepted < BEATS) begin
            bus.host_wdata_ready = toggle ? (j % 2 == 0) : 1'b1;
            if (!bus.host_wdata_ready) begin
                @(negedge clk);
                check_output("wbeat_hold", LINE_W'(bus.host_wdata), LINE_W'(base + BEAT_W'(accepted)));
                check_output("wbeat_hold_valid", LINE_W'(bus.host_wdata_valid), LINE_W'(1'b1));
            end else begin
                accepted++;
            end
            @(posedge clk); #1;
            j++;
        end
        bus.host_wdata_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int errs;
        rst                  = 1'b1;
        op_host              = 2'b00;
        AddrOut_host         = '0;
        DataOut_host         = '0;
        bus.host_cmd_ready   = 1'b0;
        bus.host_wdata_ready = 1'b0;
        bus.host_rdata       = '0;
        bus.host_rdata_valid = 1'b0;
        #3 check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("after_reset");

        $display("[TB] read, host always ready");
        apply_read(32'h0000_6044, 32'h0000_6040, 64'h0, 0, -1);

        $display("[TB] write with toggling wdata_ready");
        apply_write(32'h0000_8000, 32'h0000_8000, 64'hA5A5_0000_0000_0000, 1'b1);
        @(negedge clk);
        check_output("data_in_hold", DataIn_host, last_line);

        $display("[TB] read with 5-cycle command stall");
        apply_read(32'hABCD_E07F, 32'hABCD_E040, 64'h3000_0000_0000_0000, 5, -1);
        @(negedge clk);
        check_output("proto_err_clean", LINE_W'(proto_err), '0);

        $display("[TB] stray read beat while idle");
        @(posedge clk); #1;
        bus.host_rdata       = 64'hDEAD_BEEF_DEAD_BEEF;
        bus.host_rdata_valid = 1'b1;
        @(posedge clk); #1;
        bus.host_rdata_valid = 1'b0;
        @(negedge clk);
        check_output("proto_err_set", LINE_W'(proto_err), LINE_W'(1'b1));
        apply_read(32'h0000_1000, 32'h0000_1000, 64'h4444_0000_0000_0000, 0, -1);
        @(negedge clk);
        check_output("proto_err_sticky", LINE_W'(proto_err), LINE_W'(1'b1));

        $display("[TB] reset during beat 4, then a normal read");
        apply_read(32'h0000_2010, 32'h0000_2000, 64'h5500_0000_0000_0000, 0, 4);
        apply_read(32'h0000_3FFF, 32'h0000_3FC0, 64'h6600_0000_0000_0000, 0, -1);

        $display("[TB] reserved op held 20 cycles");
        @(posedge clk); #1;
        op_host = 2'b11;
        errs    = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.host_cmd_valid || busy || tx_done_host) errs++;
        end
        @(posedge clk); #1;
        op_host = 2'b00;
        check_output("rsvd_idle", LINE_W'(errs), '0);

        repeat (3) @(posedge clk);
        check_output("cmd_q_drained", LINE_W'(cmd_q.size()), '0);
        check_output("wq_drained", LINE_W'(wq.size()), '0);
        check_output("done_q_drained", LINE_W'(done_q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_host_dma.md
Name: mem_host_dma

Overview:
Downstream neighbour of mem_system: it serves the cache's host-side line port (op_host, AddrOut_host, DataOut_host, DataIn_host, tx_done_host, rd_valid_host).
- Converts each 512-bit line fill or writeback into one command plus a burst of BEAT_W-bit beats on the narrower host memory bus.
- Reassembles read beats into a full line.
- Signals completion back to the cache.

Parameters:
LINE_W, 512, cache line width in bits
BEAT_W, 64, host bus beat width in bits; LINE_W must be an integer multiple
ADDR_W, 32, address width
BEATS, LINE_W/BEAT_W (derived localparam, 8), beats per line
OFS_W, $clog2(LINE_W/8) (derived localparam, 6), line-offset bits cleared in host addresses

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
op_host  in  2  cache request: 00 idle, 01 read line, 10 write line, 11 reserved (treated as idle)
AddrOut_host  in  ADDR_W  cache request address
DataOut_host  in  LINE_W  writeback line from cache
DataIn_host  out  LINE_W  filled line to cache
tx_done_host  out  1  one-cycle completion pulse (read or write)
rd_valid_host  out  1  one-cycle pulse; DataIn_host is valid (reads only)
host_cmd_valid  out  1  command valid
host_cmd_ready  in  1  command accepted
host_cmd_we  out  1  1 = write burst, 0 = read burst
host_cmd_addr  out  ADDR_W  line-aligned address
host_wdata  out  BEAT_W  write beat
host_wdata_valid  out  1  write beat valid
host_wdata_ready  in  1  write beat accepted
host_rdata  in  BEAT_W  read beat
host_rdata_valid  in  1  read beat valid (no backpressure)
busy  out  1  high whenever state != IDLE
proto_err  out  1  sticky protocol error flag

Behaviour:
- Reset: async on rst high. State goes to IDLE and beat_cnt to 0. Every output listed above drives 0, including DataIn_host and proto_err. Reset mid-burst abandons the transfer; no tx_done is issued.
- States: IDLE, RD_CMD, RD_DATA, WR_CMD, WR_DATA, DONE.
- IDLE, op=01:
  - latch {AddrOut_host[ADDR_W-1:OFS_W], OFS_W'b0} into the address register
  - go to RD_CMD
- IDLE, op=10:
  - latch the aligned address
  - latch DataOut_host into the line buffer
  - go to WR_CMD
- IDLE, op=00 or 11: stay in IDLE.
- Input sampling: op, AddrOut_host and DataOut_host are sampled only in IDLE and ignored in every other state.
- RD_CMD / WR_CMD:
  - host_cmd_valid=1, host_cmd_we=0 (RD_CMD) or 1 (WR_CMD), host_cmd_addr = latched address
  - hold all three stable until host_cmd_ready
  - on the handshake cycle go to RD_DATA or WR_DATA with beat_cnt=0
- RD_DATA:
  - each cycle with host_rdata_valid, write host_rdata into line bits [beat_cnt*BEAT_W +: BEAT_W]; beat 0 is the least-significant slice
  - increment beat_cnt
  - on beat BEATS-1, go to DONE
  - gaps between beats are allowed
- WR_DATA:
  - host_wdata = line slice [beat_cnt*BEAT_W +: BEAT_W], host_wdata_valid=1
  - advance beat_cnt only when host_wdata_ready
  - after beat BEATS-1 is accepted, go to DONE; host_wdata_valid drops that same edge
- DONE (exactly one cycle):
  - tx_done_host=1
  - for reads only: rd_valid_host=1 and DataIn_host = assembled line
  - next state is IDLE
- Cache contract: mem_system deasserts op_host on the edge that ends DONE, so IDLE does not re-trigger.
- DataIn_host holding: holds its last value until the next read completes; writes never change it.
- Latency: with the host ready every cycle, op sampled in cycle 0 gives tx_done in cycle BEATS+2 (10 cycles for default parameters), for both reads and writes.
- Beat counter: width $clog2(BEATS). It is reset to 0 on entering any *_DATA state, never wraps mid-burst, and is not used outside the *_DATA states.
- proto_err: set, and held until rst, when host_rdata_valid=1 in any state other than RD_DATA. This includes the RD_CMD handshake cycle. The stray beat is discarded.
- Simultaneous events:
  - cmd handshake and rdata_valid in the same cycle: the beat is dropped and flagged as above
  - last write beat accepted while op changes: op is ignored

Decomposition:
- Package mem_host_pkg contains:
  - host_op_t enum (OP_IDLE=2'b00, OP_RD=2'b01, OP_WR=2'b10, OP_RSVD=2'b11)
  - dma_state_t enum of the six states
  - LINE_W/BEAT_W defaults
- One sub-module, line_serdes, holds the LINE_W line buffer, beat_cnt, slice write (read path) and slice select (write path). Controls: load_line, clr_cnt, rd_beat_en, wr_beat_en, last_beat.
- The top level holds the FSM, the command channel and proto_err.

Test Plan:
1. Read, host always ready, beats 64'h0..64'h7 back-to-back, AddrOut_host=32'h0000_6044:
   - host_cmd_addr=32'h0000_6040, we=0
   - tx_done_host and rd_valid_host pulse exactly 10 cycles after op sampled
   - DataIn_host = {64'h7,...,64'h0}
2. Write of DataOut_host={8{64'hA5A5_0000_0000_0000}} plus beat index in the low byte, with host_wdata_ready toggling 1,0,1,0:
   - 8 beats emitted in order, index 0..7, each held stable while not ready
   - tx_done_host pulses once, rd_valid_host stays 0
   - DataIn_host unchanged
3. host_cmd_ready held low for 5 cycles: cmd_valid/we/addr stay stable for all 5, busy=1; completion is delayed by exactly 5 cycles.
4. host_rdata_valid pulsed while IDLE, then a normal read:
   - proto_err=1 and stays 1
   - the read still completes correctly
   - the stray beat is absent from DataIn_host
5. rst asserted during beat 4 of a read:
   - all outputs are 0 asynchronously
   - state returns to IDLE, no tx_done
   - a subsequent read completes normally
6. op_host=2'b11 held 20 cycles: no host_cmd_valid, busy=0, no tx_done.
